// File: rtl/noc_master_gen.sv
// NoC traffic master: sends a header flit plus an incrementing-payload burst on NOC1 and counts responses on NOC2.
// Optional read-data compare is built in when NOC_MASTER_GEN_RESP_CHECK_EN is defined; otherwise err is tied 0.
module noc_master_gen #(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 40,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  gen_en,
   input  logic                  gen_rd,
   input  logic [ADDR_WIDTH-1:0] gen_addr,
   input  logic [CNT_WIDTH-1:0]  gen_cnt,
   input  logic [DATA_WIDTH-1:0] gen_seed,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  timeout,
   output logic [CNT_WIDTH-1:0]  resp_cnt,
   input  logic                  noc_in_rdy,
   output logic                  noc_in_valid,
   output logic [DATA_WIDTH-1:0] noc_in_data,
   input  logic                  noc_out_valid,
   input  logic [DATA_WIDTH-1:0] noc_out_data,
   output logic                  noc_out_rdy
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1);
   localparam logic [TW-1:0]         IDLE_ONE  = TW'(1);
   localparam logic [TW-1:0]         IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_RESP, S_DONE} state_t;

   state_t                state_q, state_d;
   logic                  rd_q, rd_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  idx_q, idx_d;
   logic [CNT_WIDTH-1:0]  resp_cnt_q, resp_cnt_d;
   logic [DATA_WIDTH-1:0] seed_q, seed_d;
   logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
   logic [TW-1:0]         idle_q, idle_d;
   logic                  in_valid_q, in_valid_d;
   logic                  out_rdy_q, out_rdy_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  timeout_q, timeout_d;
   logic                  in_fire, out_fire;
   logic [CNT_WIDTH-1:0]  resp_exp;

   function automatic logic [DATA_WIDTH-1:0] make_hdr(input logic                  rd,
                                                      input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [CNT_WIDTH-1:0]  cnt);
      logic [DATA_WIDTH-1:0] h;
      h                          = '0;
      h[DATA_WIDTH-1]            = rd;
      h[ADDR_WIDTH +: CNT_WIDTH] = cnt;
      h[ADDR_WIDTH-1:0]          = addr;
      return h;
   endfunction

   assign in_fire  = in_valid_q & noc_in_rdy;
   assign out_fire = out_rdy_q & noc_out_valid;
   // A write is acknowledged by a single response flit regardless of payload length.
   assign resp_exp = rd_q ? cnt_q : CNT_ONE;

   // NOTE: every output is a flop loaded from next-state values, so no output sees a combinational path from an input.
   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      seed_d     = seed_q;
      idx_d      = idx_q;
      in_data_d  = in_data_q;
      in_valid_d = in_valid_q;
      out_rdy_d  = out_rdy_q;
      resp_cnt_d = resp_cnt_q;
      idle_d     = idle_q;
      timeout_d  = timeout_q;
      unique case (state_q)
         S_IDLE: if (gen_en) begin
            rd_d       = gen_rd;
            cnt_d      = gen_cnt;
            seed_d     = gen_seed;
            resp_cnt_d = '0;
            timeout_d  = 1'b0;
            in_data_d  = make_hdr(gen_rd, gen_addr, gen_cnt);
            in_valid_d = 1'b1;
            state_d    = S_HDR;
         end
         S_HDR: if (in_fire) begin
            if (!rd_q && cnt_q != '0) begin
               in_data_d = seed_q;
               idx_d     = '0;
               state_d   = S_DATA;
            end else if (rd_q && cnt_q == '0) begin
               in_valid_d = 1'b0;
               state_d    = S_DONE;
            end else begin
               in_valid_d = 1'b0;
               out_rdy_d  = 1'b1;
               idle_d     = '0;
               state_d    = S_RESP;
            end
         end
         S_DATA: if (in_fire) begin
            if (idx_q == cnt_q - CNT_ONE) begin
               in_valid_d = 1'b0;
               out_rdy_d  = 1'b1;
               idle_d     = '0;
               state_d    = S_RESP;
            end else begin
               idx_d     = idx_q + CNT_ONE;
               in_data_d = in_data_q + DATA_ONE;
            end
         end
         S_RESP: begin
            if (out_fire) begin
               resp_cnt_d = resp_cnt_q + CNT_ONE;
               idle_d     = '0;
               if (resp_cnt_q + CNT_ONE == resp_exp) begin
                  out_rdy_d = 1'b0;
                  state_d   = S_DONE;
               end
            end else if (idle_q == IDLE_LAST) begin
               timeout_d = 1'b1;
               out_rdy_d = 1'b0;
               state_d   = S_DONE;
            end else begin
               idle_d = idle_q + IDLE_ONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rd_q       <= 1'b0;
         cnt_q      <= '0;
         seed_q     <= '0;
         idx_q      <= '0;
         in_data_q  <= '0;
         in_valid_q <= 1'b0;
         out_rdy_q  <= 1'b0;
         resp_cnt_q <= '0;
         idle_q     <= '0;
         timeout_q  <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         seed_q     <= seed_d;
         idx_q      <= idx_d;
         in_data_q  <= in_data_d;
         in_valid_q <= in_valid_d;
         out_rdy_q  <= out_rdy_d;
         resp_cnt_q <= resp_cnt_d;
         idle_q     <= idle_d;
         timeout_q  <= timeout_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

`ifdef NOC_MASTER_GEN_RESP_CHECK_EN
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] exp_data;

   // Response k of a read burst must echo seed + k; write acks carry no data to compare.
   assign exp_data = seed_q + DATA_WIDTH'(resp_cnt_q);

   always_comb begin
      err_d = err_q;
      if (state_q == S_IDLE && gen_en)
         err_d = 1'b0;
      else if (state_q == S_RESP && out_fire && rd_q && noc_out_data != exp_data)
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err = err_q;
`else
   logic unused_resp_data;
   assign unused_resp_data = ^noc_out_data;
   assign err = 1'b0;
`endif

   assign busy         = busy_q;
   assign done         = done_q;
   assign timeout      = timeout_q;
   assign resp_cnt     = resp_cnt_q;
   assign noc_in_valid = in_valid_q;
   assign noc_in_data  = in_data_q;
   assign noc_out_rdy  = out_rdy_q;

endmodule

// File: tb/tb_noc_master_gen.sv
// Bench for noc_master_gen: table of bursts driven through a TLC model, request flits scored against a queue.
// Hand-written sequences cover the mid-burst reset and the expected-value constants from the burst examples.
module tb_noc_master_gen;
   localparam int DW  = 64;
   localparam int AW  = 40;
   localparam int CW  = 16;
   localparam int TO  = 16;
   localparam int LIMIT = 400;
`ifdef NOC_MASTER_GEN_RESP_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          gen_en, gen_rd;
   logic [AW-1:0] gen_addr;
   logic [CW-1:0] gen_cnt;
   logic [DW-1:0] gen_seed;
   logic          busy, done, err, timeout;
   logic [CW-1:0] resp_cnt;
   logic          noc_in_rdy, noc_in_valid;
   logic [DW-1:0] noc_in_data;
   logic          noc_out_valid, noc_out_rdy;
   logic [DW-1:0] noc_out_data;

   always #5 clk = ~clk;

   noc_master_gen #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .gen_en(gen_en), .gen_rd(gen_rd), .gen_addr(gen_addr), .gen_cnt(gen_cnt), .gen_seed(gen_seed),
      .busy(busy), .done(done), .err(err), .timeout(timeout), .resp_cnt(resp_cnt),
      .noc_in_rdy(noc_in_rdy), .noc_in_valid(noc_in_valid), .noc_in_data(noc_in_data),
      .noc_out_valid(noc_out_valid), .noc_out_data(noc_out_data), .noc_out_rdy(noc_out_rdy)
   );

   typedef struct {
      string         name;
      logic          rd;
      logic [AW-1:0] addr;
      logic [CW-1:0] cnt;
      logic [DW-1:0] seed;
      bit            toggle;
      int            n_resp;
      int            bad_idx;
      bit            repulse;
      int            abort_at;
      logic [CW-1:0] exp_rcnt;
      logic          exp_err;
      logic          exp_to;
   } vec_t;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] resp_q[$];
   logic [DW-1:0] got_q[$];
   vec_t          vecs[7];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic rd, input logic [AW-1:0] addr,
                               input logic [CW-1:0] cnt, input logic [DW-1:0] seed, input bit toggle,
                               input int n_resp, input int bad_idx, input bit repulse, input int abort_at,
                               input logic [CW-1:0] exp_rcnt, input logic exp_err, input logic exp_to);
      vec_t v;
      v.name = name; v.rd = rd; v.addr = addr; v.cnt = cnt; v.seed = seed; v.toggle = toggle;
      v.n_resp = n_resp; v.bad_idx = bad_idx; v.repulse = repulse; v.abort_at = abort_at;
      v.exp_rcnt = exp_rcnt; v.exp_err = exp_err; v.exp_to = exp_to;
      return v;
   endfunction

   // Runs one burst; returns at a negedge, either after the post-done idle cycle or at the abort point.
   task automatic run_burst(input vec_t v);
      int   cyc, pay_cnt, done_cnt, rdy_rise, to_rise;
      bit   fin, done_prev, stall_prev, rdy_prev, to_prev, aborted;
      logic [DW-1:0] prev_data;
      exp_q.delete(); resp_q.delete(); got_q.delete();
      exp_q.push_back({v.rd, 7'b0, v.cnt, v.addr});
      if (!v.rd)
         for (int k = 0; k < int'(v.cnt); k++) exp_q.push_back(v.seed + DW'(k));
      for (int k = 0; k < v.n_resp; k++)
         resp_q.push_back(v.rd ? ((k == v.bad_idx) ? 64'h1FF : v.seed + DW'(k)) : 64'hACC);
      cyc = 0; pay_cnt = 0; done_cnt = 0; rdy_rise = -1; to_rise = -1;
      fin = 0; done_prev = 0; stall_prev = 0; rdy_prev = 0; to_prev = 1; aborted = 0;
      prev_data = '0;
      while (!fin) begin
         @(negedge clk);
         if (cyc == 0) begin
            gen_en = 1'b1; gen_rd = v.rd; gen_addr = v.addr; gen_cnt = v.cnt; gen_seed = v.seed;
         end else begin
            gen_en = v.repulse && busy;
            if (v.repulse) begin
               gen_rd = 1'b1; gen_addr = 40'h77; gen_cnt = 16'd9; gen_seed = 64'h5A5A;
            end
         end
         noc_in_rdy    = v.toggle ? (cyc % 2 == 1) : 1'b1;
         noc_out_valid = resp_q.size() != 0;
         noc_out_data  = noc_out_valid ? resp_q[0] : '0;
         if (cyc == 1) begin
            check({v.name, " valid latency"}, 64'(noc_in_valid), 64'd1);
            check({v.name, " busy on start"}, 64'(busy), 64'd1);
         end
         if (stall_prev) begin
            check({v.name, " stall data"}, noc_in_data, prev_data);
            check({v.name, " stall valid"}, 64'(noc_in_valid), 64'd1);
         end
         if (noc_in_valid && noc_in_rdy) begin
            got_q.push_back(noc_in_data);
            if (exp_q.size() == 0) check({v.name, " extra flit"}, noc_in_data, 64'hDEAD_0000_DEAD_0000 ^ ~noc_in_data);
            else check($sformatf("%s flit %0d", v.name, got_q.size() - 1), noc_in_data, exp_q.pop_front());
            if (got_q.size() > 1) pay_cnt++;
         end
         if (noc_out_valid && noc_out_rdy) void'(resp_q.pop_front());
         if (done) done_cnt++;
         if (noc_out_rdy && !rdy_prev && rdy_rise < 0) rdy_rise = cyc;
         if (timeout && !to_prev) to_rise = cyc;
         if (done_prev) begin
            check({v.name, " busy after done"}, 64'(busy), 64'd0);
            check({v.name, " out_rdy after done"}, 64'(noc_out_rdy), 64'd0);
            fin = 1;
         end
         if (v.abort_at >= 0 && pay_cnt == v.abort_at) begin
            aborted = 1; fin = 1;
         end
         if (cyc >= LIMIT && !fin) begin
            n_cmp++; n_bad++;
            $display("FAIL %s cycle budget: ran %0d cycles, limit %0d", v.name, cyc, LIMIT);
            fin = 1;
         end
         done_prev  = done;
         stall_prev = noc_in_valid && !noc_in_rdy;
         prev_data  = noc_in_data;
         rdy_prev   = noc_out_rdy;
         to_prev    = timeout;
         cyc++;
      end
      gen_en = 1'b0;
      if (!aborted) begin
         check({v.name, " flits left"}, 64'(exp_q.size()), 64'd0);
         check({v.name, " done pulses"}, 64'(done_cnt), 64'd1);
         check({v.name, " resp_cnt"}, 64'(resp_cnt), 64'(v.exp_rcnt));
         check({v.name, " err"}, 64'(err), 64'(v.exp_err));
         check({v.name, " timeout"}, 64'(timeout), 64'(v.exp_to));
         if (v.exp_to) check({v.name, " timeout latency"}, 64'(to_rise - rdy_rise), 64'(TO));
      end
   endtask

   initial begin
      int quiet;
      reset = 1'b1; gen_en = 1'b0; gen_rd = 1'b0; gen_addr = '0; gen_cnt = '0; gen_seed = '0;
      noc_in_rdy = 1'b0; noc_out_valid = 1'b0; noc_out_data = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset err", 64'(err), 64'd0);
      check("reset timeout", 64'(timeout), 64'd0);
      check("reset resp_cnt", 64'(resp_cnt), 64'd0);
      check("reset in_valid", 64'(noc_in_valid), 64'd0);
      check("reset in_data", noc_in_data, 64'd0);
      check("reset out_rdy", 64'(noc_out_rdy), 64'd0);
      reset = 1'b0;

      vecs[0] = mk("wr4 toggle", 0, 40'h10, 4, 64'hA0, 1, 1, -1, 0, -1, 1, 0, 0);
      vecs[1] = mk("rd3", 1, 40'h1234, 3, 64'h100, 0, 3, -1, 0, -1, 3, 0, 0);
      vecs[2] = mk("rd3 bad", 1, 40'h1234, 3, 64'h100, 0, 3, 1, 0, -1, 3, CHK, 0);
      vecs[3] = mk("wr0", 0, 40'hFF_FFFF_FFFF, 0, 64'h0, 1, 1, -1, 0, -1, 1, 0, 0);
      vecs[4] = mk("rd0", 1, 40'h40, 0, 64'h7, 0, 0, -1, 0, -1, 0, 0, 0);
      vecs[5] = mk("wr2 timeout", 0, 40'h20, 2, 64'h5, 0, 0, -1, 0, -1, 0, 0, 1);
      vecs[6] = mk("wrap repulse", 0, 40'h30, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, -1, 1, -1, 1, 0, 0);

      for (int i = 0; i < 7; i++) begin
         run_burst(vecs[i]);
         if (i == 0 && got_q.size() > 0) check("wr4 header const", got_q[0], 64'h0004_0000000010);
         if (i == 1 && got_q.size() > 0) check("rd3 header msb", 64'(got_q[0][DW-1]), 64'd1);
         if (i == 1) check("rd3 no payload", 64'(got_q.size()), 64'd1);
         if (i == 6 && got_q.size() >= 3) begin
            check("wrap flit0 const", got_q[1], 64'hFFFF_FFFF_FFFF_FFFF);
            check("wrap flit1 const", got_q[2], 64'h0);
         end
      end

      run_burst(mk("abort", 0, 40'h80, 5, 64'h300, 0, 1, -1, 0, 2, 1, 0, 0));
      reset = 1'b1;
      @(negedge clk);
      noc_out_valid = 1'b0;
      check("mid reset in_valid", 64'(noc_in_valid), 64'd0);
      check("mid reset busy", 64'(busy), 64'd0);
      check("mid reset done", 64'(done), 64'd0);
      check("mid reset out_rdy", 64'(noc_out_rdy), 64'd0);
      reset = 1'b0;
      quiet = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || busy || noc_in_valid) quiet++;
      end
      check("post reset quiet", 64'(quiet), 64'd0);
      run_burst(mk("after reset", 0, 40'h80, 5, 64'h300, 0, 1, -1, 0, -1, 1, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/noc_master_gen.md
Name: noc_master_gen

Overview:
- Parametrised, handshake-correct NoC traffic master for OmniXtend Core simulation benches.
- Drives request flits into the TLC on NOC1 (noc_in_*) and consumes responses from NOC2 (noc_out_*).
- Replaces ROM-file stimulus with an internally generated header + incrementing-payload burst.
- Adds full valid/ready backpressure, read/write modes, response counting, timeout, and optional read-data checking.

Parameters:
- DATA_WIDTH, 64: flit width.
- ADDR_WIDTH, 40: address field width. Requires ADDR_WIDTH+CNT_WIDTH < DATA_WIDTH.
- CNT_WIDTH, 16: payload/response count width.
- TIMEOUT_CYCLES, 1024: idle cycles allowed in RESP before abort.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- gen_en  in  1  start request; sampled only in IDLE.
- gen_rd  in  1  1 = read, 0 = write.
- gen_addr  in  ADDR_WIDTH  request address.
- gen_cnt  in  CNT_WIDTH  payload flits (write) or expected response flits (read).
- gen_seed  in  DATA_WIDTH  payload / expected-data base value.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on burst completion.
- err  out  1  sticky read-data mismatch.
- timeout  out  1  sticky response timeout.
- resp_cnt  out  CNT_WIDTH  response flits accepted in the current burst.
- noc_in_rdy  in  1  TLC ready.
- noc_in_valid  out  1  request flit valid.
- noc_in_data  out  DATA_WIDTH  request flit.
- noc_out_valid  in  1  response flit valid.
- noc_out_data  in  DATA_WIDTH  response flit.
- noc_out_rdy  out  1  ready for a response flit.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All outputs registered.
- Reset values: state=IDLE; noc_in_valid=0; noc_in_data=0; noc_out_rdy=0; busy=0; done=0; err=0; timeout=0; resp_cnt=0.
- Request transfer occurs when noc_in_valid && noc_in_rdy. While valid && !rdy, noc_in_data holds stable and valid never drops.
- Response transfer occurs when noc_out_valid && noc_out_rdy.
- IDLE:
  - On gen_en, latch gen_rd, gen_addr, gen_cnt, gen_seed.
  - Clear err, timeout and resp_cnt.
  - Go to HDR. noc_in_valid rises on the next cycle (1-cycle latency from gen_en).
  - gen_en outside IDLE is ignored.
- HDR:
  - Drive header flit: bit DATA_WIDTH-1 = rd; bits [ADDR_WIDTH+CNT_WIDTH-1:ADDR_WIDTH] = cnt; bits [ADDR_WIDTH-1:0] = addr; all other bits 0.
  - On transfer: write with cnt>0 goes to DATA; otherwise goes to RESP.
- DATA:
  - Payload flit k (k = 0..cnt-1) = seed + k, modulo 2^DATA_WIDTH (wraps).
  - After flit cnt-1 transfers, go to RESP. noc_in_valid deasserts the same edge unless the next flit is pending.
  - Back-to-back transfers at one flit per cycle when rdy is held high.
- RESP:
  - noc_out_rdy=1. Expected response count: write = 1 (ack); read = cnt.
  - Read with cnt=0 skips RESP and goes straight to DONE.
  - resp_cnt increments per accepted flit.
  - When resp_cnt reaches the expected count, go to DONE and drop noc_out_rdy on that edge.
  - Idle counter resets on each accepted flit. After TIMEOUT_CYCLES consecutive cycles without a transfer, set timeout and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. err, timeout and resp_cnt hold until the next start.
- noc_out_rdy=0 in all states except RESP. Responses arriving early stall at the TLC.
- Counters are CNT_WIDTH wide. Write with cnt=0 sends the header only and still expects 1 ack.
- Reset mid-burst: on the next edge, return to reset values. Partial flits are abandoned; no done pulse.

Optional Feature:
- Macro: NOC_MASTER_GEN_RESP_CHECK_EN.
- Defined:
  - Each accepted read-response flit k is compared with seed + k.
  - First mismatch sets err, which stays sticky until the next start.
  - Write acks are not compared.
- Undefined: no compare logic; err is tied 0.

Test Plan:
- Write, addr=0x10, cnt=4, seed=0xA0, rdy toggling 1/0 each cycle → header flit = 0x0004_0000000010; payload 0xA0..0xA3 each held stable while rdy=0; one ack accepted; done pulses once; resp_cnt=1.
- Read, cnt=3, seed=0x100, TLC returns 0x100, 0x101, 0x102 → header MSB=1; no payload flits; resp_cnt=3; done; err=0.
- Read, cnt=3, second response 0x1FF with NOC_MASTER_GEN_RESP_CHECK_EN defined → err=1 after that flit; completes with done. Same run without the macro → err=0.
- Write, cnt=2, no ack ever, TIMEOUT_CYCLES=16 → timeout=1 exactly 16 cycles after entering RESP; done pulses; busy=0 the next cycle.
- gen_en re-pulsed mid-DATA, seed=0xFFFF_FFFF_FFFF_FFFF, cnt=2 → second start ignored; payload is 0xFFFF_FFFF_FFFF_FFFF then 0x0 (wrap).
- reset asserted during DATA flit 2 of 5 → the next cycle noc_in_valid=0, busy=0, no done. A new gen_en then runs a full clean burst.
